// File: rtl/taus_urng48.sv
// Dual taus88 uniform RNG stage: sequential seed loader, warm-up FSM and 1-entry output register.
// Optional: define URNG_ZERO_SKIP_EN to suppress samples whose u0 would be zero.
module taus_urng48 #(
  parameter int unsigned WARMUP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_we,
  input  logic [31:0] seed,
  output logic        seed_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] u0,
  output logic [15:0] u1
);
  localparam int unsigned SW = 32;
  localparam int unsigned NW = 6;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WARM = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  function automatic logic [SW-1:0] taus_c1(input logic [SW-1:0] s);
    logic [SW-1:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFF_FFFE) << 12) ^ b;
  endfunction

  function automatic logic [SW-1:0] taus_c2(input logic [SW-1:0] s);
    logic [SW-1:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFF_FFF8) << 4) ^ b;
  endfunction

  function automatic logic [SW-1:0] taus_c3(input logic [SW-1:0] s);
    logic [SW-1:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFF_FFF0) << 17) ^ b;
  endfunction

  // Minimum legal value per component keeps each LFSR out of its all-zero lock-up.
  function automatic logic [SW-1:0] seed_floor(input logic [IW-1:0] idx, input logic [SW-1:0] w);
    logic [SW-1:0] lo;
    case (idx)
      3'd0, 3'd3: lo = 32'd2;
      3'd1, 3'd4: lo = 32'd8;
      default:    lo = 32'd16;
    endcase
    return (w < lo) ? lo : w;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         widx_q, widx_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [NW-1:0][SW-1:0] st_q, st_d, st_nxt;
  logic [SW-1:0]         ra, rb;
  logic                  out_valid_q, out_valid_d;
  logic                  seed_done_q, seed_done_d;
  logic [47:0]           u0_q, u0_d;
  logic [15:0]           u1_q, u1_d;

  // One generator step for both A (words 0..2) and B (words 3..5).
  always_comb begin
    st_nxt[0] = taus_c1(st_q[0]);
    st_nxt[1] = taus_c2(st_q[1]);
    st_nxt[2] = taus_c3(st_q[2]);
    st_nxt[3] = taus_c1(st_q[3]);
    st_nxt[4] = taus_c2(st_q[4]);
    st_nxt[5] = taus_c3(st_q[5]);
    ra = st_nxt[0] ^ st_nxt[1] ^ st_nxt[2];
    rb = st_nxt[3] ^ st_nxt[4] ^ st_nxt[5];
  end

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    wcnt_d      = wcnt_q;
    st_d        = st_q;
    out_valid_d = out_valid_q;
    u0_d        = u0_q;
    u1_d        = u1_q;
    seed_done_d = 1'b0;

    if (seed_we && (state_q == S_WARM || state_q == S_RUN)) begin
      // Reseed: drop any pending sample and restart the load sequence with this word.
      st_d[0]     = seed_floor(3'd0, seed);
      widx_d      = 3'd1;
      wcnt_d      = '0;
      out_valid_d = 1'b0;
      state_d     = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (seed_we) begin
            st_d[0] = seed_floor(3'd0, seed);
            widx_d  = 3'd1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (seed_we) begin
            for (int i = 0; i < NW; i++) begin
              if (widx_q == IW'(i)) st_d[i] = seed_floor(IW'(i), seed);
            end
            if (widx_q == IW'(NW - 1)) begin
              widx_d  = '0;
              wcnt_d  = '0;
              state_d = (WARMUP == 0) ? S_RUN : S_WARM;
            end else begin
              widx_d = widx_q + IW'(1);
            end
          end
        end
        S_WARM: begin
          st_d = st_nxt;
          if (wcnt_q == CW'(WARMUP - 1)) begin
            wcnt_d  = '0;
            state_d = S_RUN;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
        default: begin
          seed_done_d = 1'b1;
          if (!out_valid_q || out_ready) begin
            st_d = st_nxt;
`ifdef URNG_ZERO_SKIP_EN
            if ({ra, rb[31:16]} == 48'h0) begin
              out_valid_d = 1'b0;
            end else begin
              out_valid_d = 1'b1;
              u0_d        = {ra, rb[31:16]};
              u1_d        = rb[15:0];
            end
`else
            out_valid_d = 1'b1;
            u0_d        = {ra, rb[31:16]};
            u1_d        = rb[15:0];
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      widx_q      <= '0;
      wcnt_q      <= '0;
      st_q        <= '0;
      out_valid_q <= 1'b0;
      seed_done_q <= 1'b0;
      u0_q        <= '0;
      u1_q        <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      wcnt_q      <= wcnt_d;
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      seed_done_q <= seed_done_d;
      u0_q        <= u0_d;
      u1_q        <= u1_d;
    end
  end

  assign seed_done = seed_done_q;
  assign out_valid = out_valid_q;
  assign u0        = u0_q;
  assign u1        = u1_q;

endmodule

// File: tb/tb_taus_urng48.sv
// Directed bench for taus_urng48: two instances (WARMUP=0 and WARMUP=16) against a taus88 reference model.
module tb_taus_urng48;
  logic        clk = 1'b0;
  logic        rst;
  logic        seed_we;
  logic [31:0] seed;
  logic        out_ready;
  logic        sd0, ov0, sd1, ov1;
  logic [47:0] u0_w0, u0_w16;
  logic [15:0] u1_w0, u1_w16;

  int total = 0;
  int bad   = 0;
  int n_acc[2] = '{0, 0};
  logic [31:0] ms[2][6];
  logic [63:0] e_mon;

  always #5 clk = ~clk;

  taus_urng48 #(.WARMUP(0)) u_w0 (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed), .seed_done(sd0),
    .out_valid(ov0), .out_ready(out_ready), .u0(u0_w0), .u1(u1_w0)
  );

  taus_urng48 #(.WARMUP(16)) u_w16 (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed), .seed_done(sd1),
    .out_valid(ov1), .out_ready(out_ready), .u0(u0_w16), .u1(u1_w16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference taus88 component update, c = 0/1/2 for the three component types.
  function automatic logic [31:0] comp_step(input logic [31:0] s, input int c);
    logic [31:0] fb;
    logic [31:0] r;
    case (c)
      0: begin fb = ((s << 13) ^ s) >> 19; r = ((s & ~32'h1) << 12) ^ fb; end
      1: begin fb = ((s << 2) ^ s) >> 25;  r = ((s & ~32'h7) << 4) ^ fb;  end
      default: begin fb = ((s << 3) ^ s) >> 11; r = ((s & ~32'hF) << 17) ^ fb; end
    endcase
    return r;
  endfunction

  task automatic model_step(input int inst);
    for (int i = 0; i < 6; i++) ms[inst][i] = comp_step(ms[inst][i], i % 3);
  endtask

  function automatic logic [63:0] model_out(input int inst);
    return {ms[inst][0] ^ ms[inst][1] ^ ms[inst][2], ms[inst][3] ^ ms[inst][4] ^ ms[inst][5]};
  endfunction

  // Next presented sample as {rA, rB}; u0 = [63:16], u1 = [15:0].
  task automatic model_next(input int inst, output logic [63:0] r);
    model_step(inst);
    r = model_out(inst);
`ifdef URNG_ZERO_SKIP_EN
    for (int g = 0; g < 8 && r[63:16] == 48'h0; g++) begin
      model_step(inst);
      r = model_out(inst);
    end
`endif
  endtask

  task automatic model_peek(input int inst, output logic [63:0] r);
    logic [31:0] sv[6];
    for (int i = 0; i < 6; i++) sv[i] = ms[inst][i];
    model_next(inst, r);
    for (int i = 0; i < 6; i++) ms[inst][i] = sv[i];
  endtask

  task automatic model_seed(input int inst, input logic [31:0] w[6], input int warm);
    logic [31:0] lo;
    for (int i = 0; i < 6; i++) begin
      lo = (i % 3 == 0) ? 32'd2 : (i % 3 == 1) ? 32'd8 : 32'd16;
      ms[inst][i] = (w[i] < lo) ? lo : w[i];
    end
    for (int k = 0; k < warm; k++) model_step(inst);
  endtask

  // Every accepted sample of either instance is compared with its model.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (ov0) begin
        model_next(0, e_mon);
        check_eq("w0_u0", 64'(u0_w0), 64'(e_mon[63:16]));
        check_eq("w0_u1", 64'(u1_w0), 64'(e_mon[15:0]));
        n_acc[0]++;
      end
      if (ov1) begin
        model_next(1, e_mon);
        check_eq("w16_u0", 64'(u0_w16), 64'(e_mon[63:16]));
        check_eq("w16_u1", 64'(u1_w16), 64'(e_mon[15:0]));
        n_acc[1]++;
      end
    end
  end

  // Six seed writes; returns one step after the 6th write's capturing edge.
  task automatic load6(input logic [31:0] w[6], input int gap);
    for (int i = 0; i < 6; i++) begin
      seed_we = 1'b1;
      seed    = w[i];
      @(posedge clk); #1;
      seed_we = 1'b0;
      seed    = '0;
      if (i == 0) begin
        @(negedge clk);
        check_eq("ld_ov0", 64'(ov0), 64'd0);
        check_eq("ld_ov1", 64'(ov1), 64'd0);
        check_eq("ld_sd0", 64'(sd0), 64'd0);
        check_eq("ld_sd1", 64'(sd1), 64'd0);
        @(posedge clk); #1;
      end else if (i < 5) begin
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      end
    end
    model_seed(0, w, 0);
    model_seed(1, w, 16);
  endtask

  logic [31:0] seeds_z[6], seeds_t3[6], seeds_t5[6], seeds_zero[6], fl[6];
  logic [63:0] e;
  int nb0, nb1, cyc;

  initial begin
    seeds_z    = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    seeds_t3   = '{32'd12345, 32'd67890, 32'd13579, 32'd24680, 32'd11111, 32'd22222};
    seeds_t5   = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
    seeds_zero = '{32'h200, 32'h5000_0000, 32'd16, 32'h200, 32'h5000_0000, 32'd16};
    fl         = '{32'd2, 32'd8, 32'd16, 32'd2, 32'd8, 32'd16};
    rst = 1'b1; seed_we = 1'b0; seed = '0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_ov0", 64'(ov0), 64'd0);
    check_eq("rst_u0",  64'(u0_w0), 64'd0);
    check_eq("rst_u1",  64'(u1_w0), 64'd0);
    check_eq("rst_sd0", 64'(sd0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All-zero seeds: floors, hand-computed first two samples, then a long stream.
    load6(seeds_z, 0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) check_eq("floor", 64'(u_w0.st_q[i]), 64'(fl[i]));
    check_eq("z_k0_ov0", 64'(ov0), 64'd0);
    @(negedge clk);
    check_eq("z_k1_ov0", 64'(ov0), 64'd1);
    check_eq("z_k1_sd0", 64'(sd0), 64'd1);
    check_eq("z_k1_u0",  64'(u0_w0), 64'h0020_2080_0020);
    check_eq("z_k1_u1",  64'(u1_w0), 64'h2080);
    @(negedge clk);
    check_eq("z_k2_u0",  64'(u0_w0), 64'h0200_2C80_0200);
    check_eq("z_k2_u1",  64'(u1_w0), 64'h2C80);
    cyc = 0;
    while (n_acc[0] < 1000 && cyc < 1200) begin @(posedge clk); cyc++; end
    #1;
    check_eq("z_1000", 64'(n_acc[0] >= 1000), 64'd1);

    // Reseed mid-run with gaps; WARMUP=16 instance becomes valid 17 cycles after the 6th write.
    load6(seeds_t3, 1);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        check_eq("t3_k16_ov1", 64'(ov1), 64'd0);
        check_eq("t3_k16_sd1", 64'(sd1), 64'd0);
      end
      if (k == 17) begin
        check_eq("t3_k17_ov1", 64'(ov1), 64'd1);
        check_eq("t3_k17_sd1", 64'(sd1), 64'd1);
      end
    end

    // Backpressure: held sample must stay the next model sample.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      model_peek(1, e);
      check_eq("bp_ov1", 64'(ov1), 64'd1);
      check_eq("bp_u0",  64'(u0_w16), 64'(e[63:16]));
      check_eq("bp_u1",  64'(u1_w16), 64'(e[15:0]));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    nb1 = n_acc[1];
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_cnt", 64'(n_acc[1] - nb1), 64'd10);

    // State whose first step gives u0 == 0.
    load6(seeds_zero, 0);
    @(negedge clk);
    @(negedge clk);
`ifdef URNG_ZERO_SKIP_EN
    check_eq("zs_k1_ov0", 64'(ov0), 64'd0);
    @(negedge clk);
    check_eq("zs_k2_ov0", 64'(ov0), 64'd1);
`else
    check_eq("zs_k1_ov0", 64'(ov0), 64'd1);
    check_eq("zs_k1_u0",  64'(u0_w0), 64'd0);
    check_eq("zs_k1_u1",  64'(u1_w0), 64'd0);
`endif

    // Reseed in RUN with a fresh seed set; exact sample counts afterwards.
    @(posedge clk); #1;
    load6(seeds_t5, 0);
    nb0 = n_acc[0];
    nb1 = n_acc[1];
    repeat (40) @(posedge clk);
    #1;
    check_eq("t5_cnt0", 64'(n_acc[0] - nb0), 64'd39);
    check_eq("t5_cnt1", 64'(n_acc[1] - nb1), 64'd23);

    // Reset held two cycles mid-run.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t1_ov0", 64'(ov0), 64'd0);
    check_eq("t1_u0",  64'(u0_w0), 64'd0);
    check_eq("t1_u1",  64'(u1_w0), 64'd0);
    check_eq("t1_sd0", 64'(sd0), 64'd0);
    check_eq("t1_ov1", 64'(ov1), 64'd0);
    check_eq("t1_sd1", 64'(sd1), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Partial load, reset, then a full load must start again at sA1.
    for (int i = 0; i < 3; i++) begin
      seed_we = 1'b1;
      seed    = seeds_t5[i];
      @(posedge clk); #1;
    end
    seed_we = 1'b0;
    @(negedge clk);
    check_eq("pl_ov0", 64'(ov0), 64'd0);
    check_eq("pl_ov1", 64'(ov1), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    load6(seeds_t3, 0);
    nb0 = n_acc[0];
    nb1 = n_acc[1];
    repeat (30) @(posedge clk);
    #1;
    check_eq("pl_cnt0", 64'(n_acc[0] - nb0), 64'd29);
    check_eq("pl_cnt1", 64'(n_acc[1] - nb1), 64'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
